// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM, with per-port lock and bounded lock hold.
// Define ARB_STATS_EN to add saturating grant and forced-release counters.
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 64,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [1:0]            req_i,
  input  logic [1:0]            lock_i,
  input  logic [1:0]            we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]           stat_gnt_o,
  output logic [15:0]           stat_force_o
`endif
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W:0] HOLD_LIM = (HOLD_W+1)'(MAX_HOLD - 1);

  typedef enum logic {S_FREE, S_LOCK} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W:0]     hold_inc;
  logic [1:0]          rvalid_q;
  logic [1:0]          gnt_c;
  logic                win;
  logic                other;
  logic                force_c;
  logic                sel;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_FREE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      hold_q   <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      rvalid_q <= gnt_c & ~we_i;
    end
  end

  // Next-state and grant decision
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    gnt_c    = '0;
    force_c  = 1'b0;
    win      = 1'b0;
    other    = ~owner_q;
    hold_inc = {1'b0, hold_q} + (HOLD_W+1)'(1);
    case (state_q)
      S_FREE: begin
        win = (req_i == 2'b11) ? ~last_q : req_i[1];
        if (|req_i) begin
          gnt_c[win] = 1'b1;
          last_d     = win;
          if (lock_i[win]) begin
            state_d = S_LOCK;
            owner_d = win;
            hold_d  = '0;
          end
        end
      end
      S_LOCK: begin
        if (req_i[owner_q]) begin
          gnt_c[owner_q] = 1'b1;
          last_d         = owner_q;
        end
        if (!req_i[other]) begin
          hold_d = '0;
        end else if (req_i[owner_q]) begin
          hold_d = hold_inc[HOLD_W-1:0];
        end
        // The limit is judged on the count including this grant, so the waiting
        // port is let in right after the owner's MAX_HOLD-th consecutive grant.
        force_c = req_i[owner_q] && req_i[other] && (hold_inc >= HOLD_LIM);
        if (!req_i[owner_q] || !lock_i[owner_q] || force_c) begin
          state_d = S_FREE;
          hold_d  = '0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  // Outputs
  always_comb begin
    gnt_o       = rst_ni ? gnt_c : '0;
    rvalid_o    = rst_ni ? rvalid_q : '0;
    rdata_o     = mem_rdata_i;
    sel         = gnt_o[1];
    mem_addr_o  = sel ? addr_i[ADDR_W +: ADDR_W] : addr_i[0 +: ADDR_W];
    mem_wdata_o = sel ? wdata_i[DATA_W +: DATA_W] : wdata_i[0 +: DATA_W];
    mem_read_o  = (|gnt_o) & ~we_i[sel];
    mem_write_o = (|gnt_o) & we_i[sel];
  end

`ifdef ARB_STATS_EN
  logic [15:0] cnt0_q, cnt1_q, force_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      force_cnt_q <= '0;
    end else begin
      if (gnt_c[0] && cnt0_q != '1) cnt0_q <= cnt0_q + 16'd1;
      if (gnt_c[1] && cnt1_q != '1) cnt1_q <= cnt1_q + 16'd1;
      if (force_c && force_cnt_q != '1) force_cnt_q <= force_cnt_q + 16'd1;
    end
  end

  assign stat_gnt_o   = {cnt1_q, cnt0_q};
  assign stat_force_o = force_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with pinned literals, then random traffic,
// all checked every cycle against a behavioural arbitration and memory model.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 64;
  localparam int MAX_HOLD = 4;

  logic                clk = 1'b0;
  logic                rst_ni;
  logic [1:0]          req_i, lock_i, we_i;
  logic [2*ADDR_W-1:0] addr_i;
  logic [2*DATA_W-1:0] wdata_i;
  logic [1:0]          gnt_o, rvalid_o;
  logic [DATA_W-1:0]   rdata_o;
  logic                mem_read_o, mem_write_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W-1:0]   mem_rdata_i;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          pin_gnt = -1;
  int          pin_rv  = -1;
  bit          pin_rd_en = 1'b0;
  logic [63:0] pin_rd = '0;

  function automatic logic [63:0] init_word(int i);
    if (i == 5) return 64'hA5;
    return {32'(32'hC0DE0000 | i), 32'(i * 32'h9E3779B9)};
  endfunction

  // Write-first synchronous SRAM seen by the arbiter
  logic [DATA_W-1:0] mem [0:1023];
  initial begin
    mem_rdata_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write_o) mem[mem_addr_o] = mem_wdata_o;
      if (mem_read_o) mem_rdata_i <= mem[mem_addr_o];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: lock owner (-1 when free), last winner, count of locked
  // grants while the other port waits, and the read awaiting its return.
  logic [DATA_W-1:0] shadow [0:1023];
  initial begin
    int m_owner, m_last, m_wait, pend, win, oth;
    logic [DATA_W-1:0] pend_data, cur_rd;
    logic [1:0] exp_gnt, exp_rv;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    m_owner = -1; m_last = 1; m_wait = 0; pend = -1; pend_data = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
    forever begin
      @(negedge clk);
      exp_gnt = '0;
      exp_rv  = '0;
      cur_rd  = '0;
      if (!rst_ni) begin
        chk("rst_gnt", 64'(gnt_o), 64'(0));
        chk("rst_rvalid", 64'(rvalid_o), 64'(0));
        chk("rst_strobes", 64'({mem_read_o, mem_write_o}), 64'(0));
        m_owner = -1; m_last = 1; m_wait = 0; pend = -1;
      end else begin
        if (pend >= 0) begin
          exp_rv = 2'(1 << pend);
          cur_rd = pend_data;
          chk("rdata", rdata_o, pend_data);
        end
        chk("rvalid", 64'(rvalid_o), 64'(exp_rv));
        pend = -1;
        win  = -1;
        if (m_owner < 0) begin
          if (req_i == 2'b11) win = (m_last == 0) ? 1 : 0;
          else if (req_i[0]) win = 0;
          else if (req_i[1]) win = 1;
          if (win >= 0) begin
            m_last = win;
            if (lock_i[win]) begin m_owner = win; m_wait = 0; end
          end
        end else begin
          oth = 1 - m_owner;
          if (req_i[m_owner]) begin win = m_owner; m_last = win; end
          if (req_i[m_owner] && req_i[oth]) m_wait++;
          else if (!req_i[oth]) m_wait = 0;
          if (!req_i[m_owner] || !lock_i[m_owner] ||
              (req_i[m_owner] && req_i[oth] && m_wait >= MAX_HOLD - 1)) begin
            m_owner = -1; m_wait = 0;
          end
        end
        if (win >= 0) exp_gnt = 2'(1 << win);
        chk("gnt", 64'(gnt_o), 64'(exp_gnt));
        if (win >= 0) begin
          wa = addr_i[win*ADDR_W +: ADDR_W];
          wd = wdata_i[win*DATA_W +: DATA_W];
          chk("mem_cmd", 64'({mem_read_o, mem_write_o}), we_i[win] ? 64'(1) : 64'(2));
          chk("mem_addr", 64'(mem_addr_o), 64'(wa));
          if (we_i[win]) begin
            chk("mem_wdata", mem_wdata_o, wd);
            shadow[wa] = wd;
          end else begin
            pend = win;
            pend_data = shadow[wa];
          end
        end else begin
          chk("mem_idle", 64'({mem_read_o, mem_write_o}), 64'(0));
        end
        if (pin_rd_en) begin
          chk("pin_rdata_dut", rdata_o, pin_rd);
          chk("pin_rdata_model", cur_rd, pin_rd);
        end
      end
      if (pin_gnt >= 0) begin
        chk("pin_gnt_dut", 64'(gnt_o), 64'(pin_gnt));
        chk("pin_gnt_model", 64'(exp_gnt), 64'(pin_gnt));
      end
      if (pin_rv >= 0) begin
        chk("pin_rvalid_dut", 64'(rvalid_o), 64'(pin_rv));
        chk("pin_rvalid_model", 64'(exp_rv), 64'(pin_rv));
      end
    end
  end

  logic [1:0] g_seen;

  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                      input logic [1:0] w, input logic [ADDR_W-1:0] a0,
                      input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d0,
                      input logic [DATA_W-1:0] d1, input int pg, input int prv,
                      input bit prd_en, input logic [63:0] prd);
    rst_ni = r; req_i = rq; lock_i = lk; we_i = w;
    addr_i = {a1, a0}; wdata_i = {d1, d0};
    pin_gnt = pg; pin_rv = prv; pin_rd_en = prd_en; pin_rd = prd;
    @(negedge clk);
    g_seen = gnt_o;
    @(posedge clk);
    #1;
    pin_gnt = -1; pin_rv = -1; pin_rd_en = 1'b0;
  endtask

  logic [1:0]        p_req, p_lock, p_we;
  logic [ADDR_W-1:0] p_addr [2];
  logic [DATA_W-1:0] p_data [2];
  logic              r;

  initial begin
    rst_ni = 1'b0; req_i = '0; lock_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
    g_seen = '0;
    #1;
    for (int i = 0; i < 3; i++) step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    // T1 single read of address 5
    step(1, 2'b01, 2'b00, 2'b00, 5, 0, 0, 0, 1, -1, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 64'hA5);
    // T2 tie from reset alternates
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, 3, 4, 0, 0, 1, 0, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, 3, 4, 0, 0, 2, 1, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, 3, 4, 0, 0, 1, 2, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, 3, 4, 0, 0, 2, 1, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2, 0, 0);
    // T3 locked writes by port1, then port0 reads the freshly written word
    step(1, 2'b10, 2'b10, 2'b10, 7, 7, 0, 64'h1234_5678_9ABC_DEF0, 2, -1, 0, 0);
    step(1, 2'b11, 2'b10, 2'b10, 7, 7, 0, 64'h1234_5678_9ABC_DEF0, 2, -1, 0, 0);
    step(1, 2'b11, 2'b10, 2'b10, 7, 7, 0, 64'h1234_5678_9ABC_DEF0, 2, -1, 0, 0);
    step(1, 2'b11, 2'b00, 2'b10, 7, 7, 0, 64'h1234_5678_9ABC_DEF0, 2, -1, 0, 0);
    step(1, 2'b01, 2'b00, 2'b00, 7, 0, 0, 0, 1, 0, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 64'h1234_5678_9ABC_DEF0);
    // T4 hold limit: four port0 grants, one port1, then port0 again
    step(0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b11, 2'b01, 2'b00, 8, 9, 0, 0, 1, -1, 0, 0);
    step(1, 2'b11, 2'b01, 2'b00, 8, 9, 0, 0, 1, -1, 0, 0);
    step(1, 2'b11, 2'b01, 2'b00, 8, 9, 0, 0, 1, -1, 0, 0);
    step(1, 2'b11, 2'b01, 2'b00, 8, 9, 0, 0, 1, -1, 0, 0);
    step(1, 2'b11, 2'b01, 2'b00, 8, 9, 0, 0, 2, -1, 0, 0);
    step(1, 2'b11, 2'b01, 2'b00, 8, 9, 0, 0, 1, 2, 0, 0);
    // T5 reset right after a granted read
    step(1, 2'b01, 2'b01, 2'b00, 10, 0, 0, 0, 1, 1, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 10, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2'b01, 2'b00, 2'b00, 10, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, 10, 11, 0, 0, 1, 0, 0, 0);
    // Lock without request in free state changes nothing
    step(1, 2'b00, 2'b11, 2'b00, 0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 2'b11, 2'b00, 2'b00, 12, 13, 0, 0, 2, 0, 0, 0);
    // Random traffic; a requester holds its command until granted
    p_req = '0; p_lock = '0; p_we = '0;
    p_addr[0] = '0; p_addr[1] = '0; p_data[0] = '0; p_data[1] = '0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 199) != 0);
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] || g_seen[p]) begin
          p_req[p]  = ($urandom_range(0, 3) != 0);
          p_lock[p] = ($urandom_range(0, 1) != 0);
          p_we[p]   = ($urandom_range(0, 1) != 0);
          p_addr[p] = ADDR_W'($urandom_range(0, 15));
          p_data[p] = {$urandom, $urandom};
        end
      end
      step(r, p_req, p_lock, p_we, p_addr[0], p_addr[1], p_data[0], p_data[1], -1, -1, 0, 0);
      if (!r) g_seen = '0;
    end
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, -1, -1, 0, 0);
    step(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, -1, -1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
